// File: rtl/matmul_pkg.sv
// Shared constants and types for the matmul accelerator control path.
package matmul_pkg;
    localparam int BUS_WIDTH   = 64;
    localparam int DATA_WIDTH  = 16;
    localparam int ADDR_WIDTH  = 32;
    localparam int SP_NTARGETS = 4;

    localparam int MAX_DIM = BUS_WIDTH / DATA_WIDTH;
    localparam int DIM_W   = $clog2(MAX_DIM);
    localparam int SPW     = $clog2(SP_NTARGETS);
    // Widest count is the skew flush, 2*MAX_DIM-1 cycles.
    localparam int CNT_W   = $clog2(2 * MAX_DIM);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        RD,
        WR,
        DONE
    } ctrl_state_t;
endpackage

// File: rtl/matmul_ctrl_cnt.sv
// Loadable down-counter that holds at zero and flags its terminal count.
module matmul_ctrl_cnt
    import matmul_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         tc
);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for the matmul datapath: clear, feed K steps, flush skew, then
// write N result rows to the scratchpad with optional read-accumulate.
module matmul_ctrl
    import matmul_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [DIM_W-1:0] n_dim_i,
    input  logic [DIM_W-1:0] k_dim_i,
    input  logic [DIM_W-1:0] m_dim_i,
    input  logic             acc_mode_i,
    input  logic [SPW-1:0]   wr_target_i,
    input  logic [SPW-1:0]   rd_target_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             pe_clear_o,
    output logic             feed_valid_o,
    output logic [DIM_W-1:0] k_idx_o,
    output logic             pe_flush_o,
    output logic [DIM_W-1:0] res_row_o,
    output logic             sp_rd_en_o,
    output logic             sp_wr_en_o,
    output logic [SPW-1:0]   sp_target_o,
    output logic [DIM_W-1:0] sp_addr_o,
    output logic             sp_acc_o
);
    ctrl_state_t state_q, state_d;

    logic [DIM_W-1:0] n_q, k_q, m_q;
    logic             acc_q;
    logic [SPW-1:0]   wr_q, rd_q;

    logic             step_load, step_dec, step_tc;
    logic [CNT_W-1:0] step_val, step_cnt;
    logic             row_load, row_dec, row_tc;
    logic [CNT_W-1:0] row_val, row_cnt;
    logic [DIM_W-1:0] row_idx;

    // Operation parameters are captured only when a start is accepted.
    always_ff @(posedge clk_i) begin
        if ((state_q == IDLE) && start_i) begin
            n_q   <= n_dim_i;
            k_q   <= k_dim_i;
            m_q   <= m_dim_i;
            acc_q <= acc_mode_i;
            wr_q  <= wr_target_i;
            rd_q  <= rd_target_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    matmul_ctrl_cnt #(.W(CNT_W)) u_step_cnt (
        .clk(clk_i), .rst(rst_i), .load(step_load), .load_val(step_val),
        .dec(step_dec), .cnt(step_cnt), .tc(step_tc)
    );

    matmul_ctrl_cnt #(.W(CNT_W)) u_row_cnt (
        .clk(clk_i), .rst(rst_i), .load(row_load), .load_val(row_val),
        .dec(row_dec), .cnt(row_cnt), .tc(row_tc)
    );

    always_comb begin
        state_d   = state_q;
        step_load = 1'b0;
        step_val  = '0;
        step_dec  = 1'b0;
        row_load  = 1'b0;
        row_val   = '0;
        row_dec   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = CLEAR;
                    step_load = 1'b1;
                    step_val  = CNT_W'(k_dim_i);
                end
            end
            CLEAR: state_d = FEED;
            FEED: begin
                if (step_tc) begin
                    state_d   = FLUSH;
                    step_load = 1'b1;
                    step_val  = CNT_W'(n_q) + CNT_W'(m_q);
                end else begin
                    step_dec = 1'b1;
                end
            end
            FLUSH: begin
                if (step_tc) begin
                    state_d  = acc_q ? RD : WR;
                    row_load = 1'b1;
                    row_val  = CNT_W'(n_q);
                end else begin
                    step_dec = 1'b1;
                end
            end
            RD: state_d = WR;
            WR: begin
                if (row_tc) begin
                    state_d = DONE;
                end else begin
                    row_dec = 1'b1;
                    state_d = acc_q ? RD : WR;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row counter runs down from N-1, so the row index is its complement.
    assign row_idx = DIM_W'(CNT_W'(n_q) - row_cnt);

    always_comb begin
        busy_o       = (state_q != IDLE);
        done_o       = (state_q == DONE);
        pe_clear_o   = (state_q == CLEAR);
        feed_valid_o = (state_q == FEED);
        k_idx_o      = '0;
        pe_flush_o   = (state_q == FLUSH);
        res_row_o    = '0;
        sp_rd_en_o   = (state_q == RD);
        sp_wr_en_o   = (state_q == WR);
        sp_target_o  = '0;
        sp_addr_o    = '0;
        sp_acc_o     = 1'b0;
        if (state_q == FEED) k_idx_o = DIM_W'(CNT_W'(k_q) - step_cnt);
        if (state_q == RD) begin
            sp_target_o = rd_q;
            sp_addr_o   = row_idx;
        end
        if (state_q == WR) begin
            sp_target_o = wr_q;
            sp_addr_o   = row_idx;
            res_row_o   = row_idx;
            sp_acc_o    = acc_q;
        end
    end
endmodule

// File: tb/tb_matmul_ctrl.sv
// Bench for matmul_ctrl: per-cycle expected output records queued at start,
// popped and compared every cycle while the operation runs.
module tb_matmul_ctrl;
    import matmul_pkg::*;

    typedef struct packed {
        logic             busy, done, clr, fv;
        logic [DIM_W-1:0] kidx;
        logic             fl;
        logic [DIM_W-1:0] row;
        logic             rde, wre;
        logic [SPW-1:0]   tgt;
        logic [DIM_W-1:0] addr;
        logic             acc;
    } out_t;

    typedef struct {
        int n, k, m;
        bit acc;
        int rd, wr;
        int done_cyc;
    } vec_t;

    logic clk = 1'b0;
    logic rst, start, acc_mode;
    logic [DIM_W-1:0] n_dim, k_dim, m_dim, k_idx, res_row, sp_addr;
    logic [SPW-1:0] wr_target, rd_target, sp_target;
    logic busy, done, pe_clear, feed_valid, pe_flush, sp_rd_en, sp_wr_en, sp_acc;

    out_t act;
    out_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   start_cyc = 0;
    int   done_at = -1;

    matmul_ctrl dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .n_dim_i(n_dim), .k_dim_i(k_dim), .m_dim_i(m_dim),
        .acc_mode_i(acc_mode), .wr_target_i(wr_target), .rd_target_i(rd_target),
        .busy_o(busy), .done_o(done), .pe_clear_o(pe_clear),
        .feed_valid_o(feed_valid), .k_idx_o(k_idx), .pe_flush_o(pe_flush),
        .res_row_o(res_row), .sp_rd_en_o(sp_rd_en), .sp_wr_en_o(sp_wr_en),
        .sp_target_o(sp_target), .sp_addr_o(sp_addr), .sp_acc_o(sp_acc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign act = {busy, done, pe_clear, feed_valid, k_idx, pe_flush, res_row,
                  sp_rd_en, sp_wr_en, sp_target, sp_addr, sp_acc};

    always @(negedge clk) begin
        out_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act === e) passes++;
            else $display("FAIL outputs at op cycle %0d: got %h expected %h",
                          cyc - start_cyc, act, e);
        end
        if (done === 1'b1) done_at = cyc - start_cyc;
    end

    // Independent cycle-by-cycle model of one operation; limit<0 pushes all.
    task automatic push_model(input int n, k, m, input bit acc, input int rd, wr,
                              input int limit);
        out_t l[$];
        out_t r;
        l.push_back('0);
        r = '0; r.busy = 1'b1; r.clr = 1'b1; l.push_back(r);
        for (int i = 0; i < k; i++) begin
            r = '0; r.busy = 1'b1; r.fv = 1'b1; r.kidx = DIM_W'(i); l.push_back(r);
        end
        for (int i = 0; i < n + m - 1; i++) begin
            r = '0; r.busy = 1'b1; r.fl = 1'b1; l.push_back(r);
        end
        for (int row = 0; row < n; row++) begin
            if (acc) begin
                r = '0; r.busy = 1'b1; r.rde = 1'b1;
                r.tgt = SPW'(rd); r.addr = DIM_W'(row); l.push_back(r);
            end
            r = '0; r.busy = 1'b1; r.wre = 1'b1; r.tgt = SPW'(wr);
            r.addr = DIM_W'(row); r.row = DIM_W'(row); r.acc = acc; l.push_back(r);
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1; l.push_back(r);
        for (int i = 0; i < l.size() && (limit < 0 || i < limit); i++)
            exp_q.push_back(l[i]);
    endtask

    task automatic start_op(input int n, k, m, input bit acc, input int rd, wr,
                            input int limit);
        n_dim = DIM_W'(n - 1);
        k_dim = DIM_W'(k - 1);
        m_dim = DIM_W'(m - 1);
        acc_mode = acc;
        rd_target = SPW'(rd);
        wr_target = SPW'(wr);
        start = 1'b1;
        start_cyc = cyc;
        done_at = -1;
        push_model(n, k, m, acc, rd, wr, limit);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drain();
        int i = 0;
        do begin
            @(posedge clk);
            i++;
        end while (exp_q.size() > 0 && i < 300);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain timeout: %0d records left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_done(input string name, input int expv);
        checks++;
        if (done_at == expv) passes++;
        else $display("FAIL %s done cycle: got %0d required %0d", name, done_at, expv);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{n:4, k:4, m:4, acc:1'b0, rd:0, wr:2, done_cyc:17};
        vecs[1] = '{n:2, k:3, m:1, acc:1'b1, rd:1, wr:3, done_cyc:11};
        vecs[2] = '{n:1, k:1, m:1, acc:1'b0, rd:0, wr:0, done_cyc:5};
        vecs[3] = '{n:3, k:2, m:4, acc:1'b1, rd:2, wr:2, done_cyc:16};
        vecs[4] = '{n:1, k:4, m:2, acc:1'b1, rd:0, wr:1, done_cyc:10};

        rst = 1'b1; start = 1'b0; acc_mode = 1'b0;
        n_dim = '0; k_dim = '0; m_dim = '0; wr_target = '0; rd_target = '0;
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Start coincident with reset must be dropped.
        rst = 1'b1; start = 1'b1; n_dim = 2'd3; k_dim = 2'd3; m_dim = 2'd3;
        exp_q.push_back('0);
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        drain();

        // Table entries run back-to-back: each start lands the cycle after done.
        for (int i = 0; i < 5; i++) begin
            start_op(vecs[i].n, vecs[i].k, vecs[i].m, vecs[i].acc,
                     vecs[i].rd, vecs[i].wr, -1);
            drain();
            check_done($sformatf("vec%0d", i), vecs[i].done_cyc);
        end

        // Start pulse during FEED with different settings is ignored.
        start_op(4, 4, 4, 1'b0, 0, 2, -1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1; n_dim = '0; k_dim = '0; m_dim = '0;
        acc_mode = 1'b1; wr_target = 2'd1; rd_target = 2'd3;
        @(posedge clk); #1;
        start = 1'b0;
        drain();
        check_done("start_in_feed", 17);

        // Reset during FLUSH (cycle 8) aborts with no done pulse.
        start_op(4, 4, 4, 1'b0, 0, 2, 9);
        repeat (7) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.push_back('0);
        exp_q.push_back('0);
        @(posedge clk); #1;
        rst = 1'b0;
        drain();
        check_done("reset_in_flush", -1);

        start_op(2, 3, 1, 1'b1, 1, 3, -1);
        drain();
        check_done("after_reset", 11);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
